// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioning stage: channel state
// encodings and default timing for the 50 MHz board clock.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_UP     = 2'b00,
        ST_DEB_DN = 2'b01,
        ST_DOWN   = 2'b10,
        ST_DEB_UP = 2'b11
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 50000000;

    // The debounced level is a pure function of the state: high while the
    // press is accepted, including while a release is still being qualified.
    function automatic logic state_is_pressed(key_state_t s);
        return (s == ST_DOWN) || (s == ST_DEB_UP);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, stability-counter debounce FSM
// and press/release strobes. KEY_LONGPRESS_EN adds a one-shot long-press strobe.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("key_debounce_ch: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic [1:0]       sync_q;
    logic             sync;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchroniser presets to "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign sync = ~sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_UP: begin
                if (sync) begin
                    state_d = ST_DEB_DN;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEB_DN: begin
                if (!sync) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!sync) begin
                    state_d = ST_DEB_UP;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEB_UP: begin
                if (sync) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_UP;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level   = state_is_pressed(state_q);
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ARM  = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold time counts from the accepted press; a release glitch that bounces
    // back to DOWN keeps counting, and saturation limits it to one strobe.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d || state_d == ST_UP) begin
            hold_d = '0;
        end else if (state_is_pressed(state_q) && hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_ARM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounce stage for the DE0-Nano KEY buttons: NUM_KEYS independent channels.
// Define KEY_LONGPRESS_EN to enable the per-key long-press strobe.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with short timing (16 / 64 clocks).
// Long-press expectations follow KEY_LONGPRESS_EN as the RTL is built.
module tb_key_debounce;

    localparam int NK  = 2;
    localparam int DEB = 16;
    localparam int LNG = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    key_debounce #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the pressed value seen by the debouncer lags the pin by two
    // clocks; the level flips once DEB consecutive samples disagree with it.
    logic [NK-1:0] m_p1 = '0, m_p2 = '0, m_lvl = '0;
    logic [NK-1:0] exp_press = '0, exp_release = '0, exp_long = '0;
    int            m_run[NK]   = '{0, 0};
    int            m_since[NK] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin : model_step
        logic [NK-1:0] lvl_n, pr, rl, lg;
        int            run_n[NK];
        int            since_n[NK];
        if (!rst_n) begin
            m_p1        <= '0;
            m_p2        <= '0;
            m_lvl       <= '0;
            m_run       <= '{0, 0};
            m_since     <= '{0, 0};
            exp_press   <= '0;
            exp_release <= '0;
            exp_long    <= '0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                lvl_n[k]   = m_lvl[k];
                run_n[k]   = 0;
                since_n[k] = m_since[k];
                pr[k]      = 1'b0;
                rl[k]      = 1'b0;
                lg[k]      = 1'b0;
                if (m_p2[k] != m_lvl[k]) begin
                    run_n[k] = m_run[k] + 1;
                    if (run_n[k] == DEB) begin
                        lvl_n[k] = m_p2[k];
                        run_n[k] = 0;
                        if (m_p2[k]) begin
                            pr[k]      = 1'b1;
                            since_n[k] = 0;
                        end else begin
                            rl[k] = 1'b1;
                        end
                    end
                end
                if (lvl_n[k] && !pr[k]) begin
                    since_n[k] = m_since[k] + 1;
`ifdef KEY_LONGPRESS_EN
                    lg[k] = (since_n[k] == LNG - 1);
`endif
                end
            end
            m_lvl       <= lvl_n;
            m_run       <= run_n;
            m_since     <= since_n;
            exp_press   <= pr;
            exp_release <= rl;
            exp_long    <= lg;
            m_p2        <= m_p1;
            m_p1        <= ~key_n;
        end
    end

    int press_cyc[NK], release_cyc[NK], long_cyc[NK];
    int press_cnt[NK], release_cnt[NK], long_cnt[NK];

    task automatic clearEvents();
        for (int k = 0; k < NK; k++) begin
            press_cyc[k]   = -1000;
            release_cyc[k] = -1000;
            long_cyc[k]    = -1000;
            press_cnt[k]   = 0;
            release_cnt[k] = 0;
            long_cnt[k]    = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Every clock: compare against the model on the falling edge, log strobes,
    // then step past the edge so new stimulus lands well away from it.
    task automatic tick();
        @(negedge clk);
        checkOutput("cycle_outputs",
                    32'({key_level, key_press, key_release, key_long}),
                    32'({m_lvl, exp_press, exp_release, exp_long}));
        for (int k = 0; k < NK; k++) begin
            if (key_press[k]) begin
                press_cyc[k] = cyc;
                press_cnt[k]++;
            end
            if (key_release[k]) begin
                release_cyc[k] = cyc;
                release_cnt[k]++;
            end
            if (key_long[k]) begin
                long_cyc[k] = cyc;
                long_cnt[k]++;
            end
        end
        #2;
    endtask

    task automatic applyStimulus(input logic [NK-1:0] kn, input logic rn, input int cycles);
        key_n = kn;
        rst_n = rn;
        repeat (cycles) tick();
    endtask

    initial begin
        int t0;
        clearEvents();
        key_n = 2'b00;
        rst_n = 1'b0;
        repeat (4) tick();
        checkOutput("reset_outputs",
                    32'({key_level, key_press, key_release, key_long}), 32'h0);

        // Both keys already held when reset lifts.
        clearEvents();
        t0 = cyc;
        applyStimulus(2'b00, 1'b1, 20);
        checkOutput("reset_release_press0_delay", 32'(press_cyc[0] - t0), 32'd18);
        checkOutput("reset_release_press1_delay", 32'(press_cyc[1] - t0), 32'd18);
        checkOutput("reset_release_press_count", 32'(press_cnt[0] + press_cnt[1]), 32'd2);
        checkOutput("reset_release_level", 32'(key_level), 32'h3);
        applyStimulus(2'b11, 1'b1, 30);
        checkOutput("both_released_level", 32'(key_level), 32'h0);

        // Clean press on key 0, then a 15-clock glitch, then release.
        clearEvents();
        t0 = cyc;
        applyStimulus(2'b10, 1'b1, 25);
        checkOutput("clean_press_delay", 32'(press_cyc[0] - t0), 32'd18);
        checkOutput("clean_press_count", 32'(press_cnt[0]), 32'd1);
        checkOutput("clean_press_other_key", 32'(press_cnt[1]), 32'd0);
        checkOutput("clean_press_level", 32'(key_level), 32'h1);
        applyStimulus(2'b11, 1'b1, 15);
        applyStimulus(2'b10, 1'b1, 20);
        checkOutput("glitch_no_release", 32'(release_cnt[0]), 32'd0);
        checkOutput("glitch_level_held", 32'(key_level[0]), 32'd1);
        t0 = cyc;
        applyStimulus(2'b11, 1'b1, 25);
        checkOutput("release_delay", 32'(release_cyc[0] - t0), 32'd18);
        checkOutput("release_count", 32'(release_cnt[0]), 32'd1);

        // Bounce: short low bursts never qualify.
        clearEvents();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(2'b10, 1'b1, 10);
            applyStimulus(2'b11, 1'b1, 3);
        end
        applyStimulus(2'b11, 1'b1, 20);
        checkOutput("bounce_no_press", 32'(press_cnt[0]), 32'd0);
        checkOutput("bounce_no_release", 32'(release_cnt[0]), 32'd0);

        // Long press on key 1, then re-arm after a release.
        clearEvents();
        applyStimulus(2'b01, 1'b1, 200);
        checkOutput("long_press_count", 32'(press_cnt[1]), 32'd1);
`ifdef KEY_LONGPRESS_EN
        checkOutput("long_count", 32'(long_cnt[1]), 32'd1);
        checkOutput("long_delay", 32'(long_cyc[1] - press_cyc[1]), 32'd63);
`else
        checkOutput("long_absent", 32'(long_cnt[1]), 32'd0);
`endif
        applyStimulus(2'b11, 1'b1, 30);
        clearEvents();
        applyStimulus(2'b01, 1'b1, 100);
`ifdef KEY_LONGPRESS_EN
        checkOutput("long_rearm_count", 32'(long_cnt[1]), 32'd1);
`else
        checkOutput("long_rearm_absent", 32'(long_cnt[1]), 32'd0);
`endif
        applyStimulus(2'b11, 1'b1, 30);

        // Reset eight clocks into the press qualification of key 0.
        clearEvents();
        applyStimulus(2'b10, 1'b1, 10);
        key_n = 2'b10;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_outputs",
                    32'({key_level, key_press, key_release, key_long}), 32'h0);
        applyStimulus(2'b10, 1'b0, 3);
        checkOutput("mid_reset_no_press", 32'(press_cnt[0]), 32'd0);
        t0 = cyc;
        applyStimulus(2'b10, 1'b1, 25);
        checkOutput("post_reset_press_delay", 32'(press_cyc[0] - t0), 32'd18);
        checkOutput("post_reset_press_count", 32'(press_cnt[0]), 32'd1);
        applyStimulus(2'b11, 1'b1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
